// File: rtl/video_in.sv
// video_in: receive side of the composite data-tape video link.
// Samples the played-back composite signal, recovers horizontal and vertical
// sync, qualifies active lines and extracts the data bytes between the start
// and end control markers of each active line.
//
// Ports:
//   clkin        sample clock (one ADC sample per cycle, 400 samples per line)
//   reset        synchronous, active-high reset
//   adc_in       8-bit digitized composite sample
//   data_out     recovered data byte (registered, one cycle after its sample)
//   data_valid   data_out holds a byte of the current line this cycle
//   line_ctrl    start marker of the current/last line was control-enabled
//   line_done    one-cycle pulse at the end (or abort) of each active line
//   line_ok      qualifies line_done: end marker class matches start marker class
//   field_toggle toggles once per detected vertical interval
//   locked       vertical sync acquired and no sync timeout since
module video_in #(
  parameter int SYNC_THRESH  = 20,
  parameter int GLITCH_MAX   = 3,
  parameter int HSYNC_MIN    = 20,
  parameter int BROAD_MIN    = 100,
  parameter int MARK_HI      = 120,
  parameter int ACTIVE_FIRST = 11,
  parameter int ACTIVE_LAST  = 253,
  parameter int TIMEOUT      = 800
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic [7:0] adc_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       line_ctrl,
  output logic       line_done,
  output logic       line_ok,
  output logic       field_toggle,
  output logic       locked
);

  typedef enum logic [2:0] {
    ST_SEARCH = 3'd0,
    ST_VBLANK = 3'd1,
    ST_LINE   = 3'd2,
    ST_DATA   = 3'd3,
    ST_END    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PC_NONE  = 2'd0,
    PC_EQ    = 2'd1,
    PC_HSYNC = 2'd2,
    PC_BROAD = 2'd3
  } pulse_t;

  state_t      state_r;
  logic [7:0]  run_len_r;
  logic [15:0] pixel_r;
  logic [8:0]  hs_idx_r;
  logic        broad_seen_r;
  logic [7:0]  data_out_r;
  logic        data_valid_r;
  logic        line_ctrl_r;
  logic        line_done_r;
  logic        line_ok_r;
  logic        field_toggle_r;
  logic        locked_r;

  logic        below_s;
  logic        mark_hi_s;
  logic [7:0]  run_inc_s;
  logic        confirm_s;
  logic [15:0] pix_s;
  logic [8:0]  hs_inc_s;
  pulse_t      pulse_s;
  logic        at58_s;
  logic        go_line_s;
  logic        timeout_s;

  // Front end: threshold, run length, pixel position of this sample, pulse class
  always_comb begin
    below_s   = (adc_in < 8'(SYNC_THRESH));
    mark_hi_s = (adc_in >= 8'(MARK_HI));
    if (run_len_r == 8'd255) run_inc_s = 8'd255;
    else                     run_inc_s = run_len_r + 8'd1;
    // A run is only trusted once it outlasts a glitch; the pixel count is then
    // restarted retroactively so that the run's first sample was pixel 1.
    confirm_s = below_s && (run_len_r == 8'(GLITCH_MAX));
    if (confirm_s) pix_s = 16'(GLITCH_MAX + 1);
    else           pix_s = pixel_r + 16'd1;
    if (hs_idx_r == 9'd511) hs_inc_s = 9'd511;
    else                    hs_inc_s = hs_idx_r + 9'd1;
    pulse_s = PC_NONE;
    if (!below_s && (run_len_r > 8'(GLITCH_MAX))) begin
      if (run_len_r < 8'(HSYNC_MIN))      pulse_s = PC_EQ;
      else if (run_len_r < 8'(BROAD_MIN)) pulse_s = PC_HSYNC;
      else                                pulse_s = PC_BROAD;
    end else begin
      pulse_s = PC_NONE;
    end
    at58_s    = (pix_s == 16'd58);
    go_line_s = (hs_inc_s <= 9'(ACTIVE_LAST));
    timeout_s = (locked_r || (state_r != ST_SEARCH)) && (pix_s == 16'(TIMEOUT + 1));
  end

  // Sync tracking, line state machine and registered outputs
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_r        <= ST_SEARCH;
      run_len_r      <= 8'd0;
      pixel_r        <= 16'd0;
      hs_idx_r       <= 9'd0;
      broad_seen_r   <= 1'b0;
      data_out_r     <= 8'd0;
      data_valid_r   <= 1'b0;
      line_ctrl_r    <= 1'b0;
      line_done_r    <= 1'b0;
      line_ok_r      <= 1'b0;
      field_toggle_r <= 1'b0;
      locked_r       <= 1'b0;
    end else begin
      run_len_r    <= below_s ? run_inc_s : 8'd0;
      pixel_r      <= pix_s;
      data_valid_r <= 1'b0;
      line_done_r  <= 1'b0;
      line_ok_r    <= 1'b0;
      case (state_r)
        ST_SEARCH: begin
          state_r <= ST_SEARCH;
        end
        ST_VBLANK: begin
          if (pulse_s == PC_HSYNC) begin
            hs_idx_r <= hs_inc_s;
            if (hs_inc_s == 9'(ACTIVE_FIRST)) begin
              state_r <= at58_s ? ST_DATA : ST_LINE;
              if (at58_s) line_ctrl_r <= mark_hi_s;
            end
          end
        end
        ST_LINE: begin
          // A sync before the start marker simply restarts the pixel count.
          if ((pulse_s == PC_HSYNC) && !go_line_s) begin
            hs_idx_r <= hs_inc_s;
            state_r  <= ST_VBLANK;
          end else begin
            if (pulse_s == PC_HSYNC) hs_idx_r <= hs_inc_s;
            if (at58_s) begin
              line_ctrl_r <= mark_hi_s;
              state_r     <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (confirm_s || timeout_s) begin
            line_done_r <= 1'b1;
            line_ok_r   <= 1'b0;
            state_r     <= ST_END;
          end else if ((pix_s >= 16'd59) && (pix_s <= 16'd389)) begin
            data_out_r   <= adc_in;
            data_valid_r <= 1'b1;
          end else if (pix_s == 16'd390) begin
            line_done_r <= 1'b1;
            line_ok_r   <= (mark_hi_s == line_ctrl_r);
            state_r     <= ST_END;
          end
        end
        ST_END: begin
          if (pulse_s == PC_HSYNC) begin
            hs_idx_r <= hs_inc_s;
            if (go_line_s) begin
              state_r <= at58_s ? ST_DATA : ST_LINE;
              if (at58_s) line_ctrl_r <= mark_hi_s;
            end else begin
              state_r <= ST_VBLANK;
            end
          end
        end
        default: begin
          state_r <= ST_SEARCH;
        end
      endcase
      if (pulse_s == PC_HSYNC) broad_seen_r <= 1'b0;
      if (timeout_s) begin
        locked_r     <= 1'b0;
        state_r      <= ST_SEARCH;
        broad_seen_r <= 1'b0;
      end
      // Broad pulses win over everything; a run of them toggles the field once.
      if (pulse_s == PC_BROAD) begin
        hs_idx_r     <= 9'd0;
        locked_r     <= 1'b1;
        state_r      <= ST_VBLANK;
        broad_seen_r <= 1'b1;
        if (!broad_seen_r) field_toggle_r <= ~field_toggle_r;
      end
    end
  end

  assign data_out     = data_out_r;
  assign data_valid   = data_valid_r;
  assign line_ctrl    = line_ctrl_r;
  assign line_done    = line_done_r;
  assign line_ok      = line_ok_r;
  assign field_toggle = field_toggle_r;
  assign locked       = locked_r;

endmodule

// File: tb/tb_video_in.sv
// tb_video_in: directed field sequences with randomized line content for video_in.
// Each line is built as a 400-sample array; the expected outputs for every
// sample follow from where the bench placed syncs, markers, data and dips.
module tb_video_in;

  localparam int AF      = 4;
  localparam int AL      = 8;
  localparam int MARK_HI = 120;

  logic       clkin = 1'b0;
  logic       reset;
  logic [7:0] adc_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       line_ctrl;
  logic       line_done;
  logic       line_ok;
  logic       field_toggle;
  logic       locked;

  int checks   = 0;
  int failures = 0;
  bit exp_field  = 1'b0;
  bit exp_locked = 1'b0;

  video_in #(.ACTIVE_FIRST(AF), .ACTIVE_LAST(AL)) dut (
    .clkin(clkin), .reset(reset), .adc_in(adc_in),
    .data_out(data_out), .data_valid(data_valid), .line_ctrl(line_ctrl),
    .line_done(line_done), .line_ok(line_ok), .field_toggle(field_toggle),
    .locked(locked)
  );

  always #5 clkin = ~clkin;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic [7:0] v, input bit rst);
    adc_in = v;
    reset  = rst;
    @(posedge clkin);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".data_out"}, 16'(data_out), 16'd0);
    chk({tag, ".data_valid"}, 16'(data_valid), 16'd0);
    chk({tag, ".line_ctrl"}, 16'(line_ctrl), 16'd0);
    chk({tag, ".line_done"}, 16'(line_done), 16'd0);
    chk({tag, ".line_ok"}, 16'(line_ok), 16'd0);
    chk({tag, ".field_toggle"}, 16'(field_toggle), 16'd0);
    chk({tag, ".locked"}, 16'(locked), 16'd0);
  endtask

  task automatic line_status();
    chk("locked", 16'(locked), 16'(exp_locked));
    chk("field_toggle", 16'(field_toggle), 16'(exp_field));
  endtask

  function automatic logic [7:0] pick_mark(input bit hi);
    bit r;
    r = 1'($urandom_range(0, 1));
    if (hi) return r ? 8'd200 : 8'd180;
    else    return r ? 8'd49 : 8'd42;
  endfunction

  // n sync pulses of width w, 200 samples apart, on a blank line
  task automatic pulse_line(input int w, input int n);
    logic [7:0] v;
    for (int p = 1; p <= 400; p++) begin
      v = ((((p - 1) % 200) < w) && (((p - 1) / 200) < n)) ? 8'd0 : 8'd41;
      step(v, 1'b0);
      chk("pulse.data_valid", 16'(data_valid), 16'd0);
      chk("pulse.line_done", 16'(line_done), 16'd0);
    end
  endtask

  // One hsync line carrying markers and random data; optional dip and reset
  task automatic send_line(input bit active, input logic [7:0] sm, input logic [7:0] em,
                           input int dpos, input int dlen, input int rpx);
    logic [7:0] s [1:400];
    logic [7:0] b;
    logic [7:0] prev;
    int  abort_at;
    bit  alive;
    bit  ev;
    bit  ed;
    bit  eok;
    for (int p = 1; p <= 400; p++) s[p] = (p <= 29) ? 8'd0 : 8'd41;
    s[58] = sm;
    prev  = sm;
    for (int p = 59; p <= 389; p++) begin
      b = 8'($urandom);
      if (prev < 8'd20) b = b | 8'h40;
      s[p] = b;
      prev = b;
    end
    s[390] = em;
    if (dlen > 0) begin
      s[dpos - 1]    = s[dpos - 1] | 8'h40;
      s[dpos + dlen] = s[dpos + dlen] | 8'h40;
      for (int k = 0; k < dlen; k++) s[dpos + k] = 8'd0;
    end
    // a dip longer than a glitch is recognised on its 4th low sample
    abort_at = (active && (dlen > 3)) ? (dpos + 3) : 0;
    alive    = active;
    for (int p = 1; p <= 400; p++) begin
      step(s[p], (p == rpx));
      if (p == rpx) begin
        chk_zero("reset_midline");
        alive      = 1'b0;
        exp_locked = 1'b0;
        exp_field  = 1'b0;
      end else begin
        ev = alive && (p >= 59) && (p <= 389) && ((abort_at == 0) || (p < abort_at));
        ed = alive && ((p == 390) || (p == abort_at));
        chk("data_valid", 16'(data_valid), 16'(ev));
        if (ev) chk("data_out", 16'(data_out), 16'(s[p]));
        chk("line_done", 16'(line_done), 16'(ed));
        if (ed) begin
          eok = (p == abort_at) ? 1'b0 : ((sm >= 8'(MARK_HI)) == (em >= 8'(MARK_HI)));
          chk("line_ok", 16'(line_ok), 16'(eok));
          chk("line_ctrl", 16'(line_ctrl), 16'(sm >= 8'(MARK_HI)));
        end
        if (p == abort_at) alive = 1'b0;
      end
    end
  endtask

  // Vertical interval (eq, broad, broad, eq) followed by AL+2 hsync lines
  task automatic field(input bit rnd_marks, input int bad_idx, input int glitch_idx,
                       input int dip_idx, input int rst_idx);
    bit dead;
    bit act;
    bit c;
    logic [7:0] sm;
    logic [7:0] em;
    int dpos;
    int dlen;
    int rpx;
    dead = 1'b0;
    pulse_line(14, 2);
    line_status();
    pulse_line(170, 1);
    exp_field  = ~exp_field;
    exp_locked = 1'b1;
    line_status();
    pulse_line(170, 1);
    line_status();
    pulse_line(14, 2);
    line_status();
    for (int idx = 1; idx <= AL + 2; idx++) begin
      act = (idx >= AF) && (idx <= AL) && !dead;
      c   = 1'($urandom_range(0, 1));
      sm  = pick_mark(c);
      em  = rnd_marks ? pick_mark(1'($urandom_range(0, 1))) : pick_mark(c);
      if (idx == bad_idx) begin
        sm = 8'd180;
        em = 8'd49;
      end
      dpos = 0;
      dlen = 0;
      rpx  = 0;
      if (idx == glitch_idx) begin
        dpos = 200;
        dlen = $urandom_range(1, 3);
      end
      if (idx == dip_idx) begin
        dpos = 200;
        dlen = 25;
      end
      if (idx == rst_idx) rpx = 150;
      send_line(act, sm, em, dpos, dlen, rpx);
      if (idx == rst_idx) dead = 1'b1;
      line_status();
    end
  endtask

  // hsync then constant blank: lock must drop after 800 edge-free samples
  task automatic timeout_test();
    for (int p = 1; p <= 1000; p++) begin
      step((p <= 29) ? 8'd0 : 8'd41, 1'b0);
      chk("timeout.data_valid", 16'(data_valid), 16'd0);
      if (p == 800) chk("timeout.locked_held", 16'(locked), 16'd1);
      if (p == 801) chk("timeout.locked_drop", 16'(locked), 16'd0);
    end
    exp_locked = 1'b0;
    line_status();
  endtask

  initial begin
    reset  = 1'b1;
    adc_in = 8'd41;
    for (int i = 0; i < 3; i++) step(8'd41, 1'b1);
    chk_zero("reset");

    field(1'b0, -1, -1, -1, -1);
    field(1'b1, AF + 1, AF + 2, -1, -1);
    field(1'b0, -1, AF, AL, -1);
    timeout_test();
    for (int i = 0; i < 2; i++) begin
      send_line(1'b0, 8'd180, 8'd200, 0, 0, 0);
      line_status();
    end
    field(1'b0, -1, -1, -1, -1);
    field(1'b0, -1, -1, -1, AF + 1);
    for (int i = 0; i < 2; i++) begin
      send_line(1'b0, 8'd180, 8'd200, 0, 0, 0);
      line_status();
    end
    field(1'b1, -1, AL, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
